// File: rtl/layer_seq.sv
// ---------------------------------------------------------------------------
// layer_seq -- sequencer for one fully-connected neural-network layer.
//
// Loads N_IN signed fixed-point activations from a valid/ready stream, then
// for each of N_OUT neurons reads N_IN weights plus one bias word from an
// external ROM (1-cycle read latency). It forms the dot product with one
// shared signed multiplier and one accumulator. The bias is added, the sum is
// rescaled by FRAC bits with a floor shift, saturated to DW bits, and each
// result is emitted on a valid/ready output stream.
//
// ROM layout: neuron j owns words j*(N_IN+1) .. j*(N_IN+1)+N_IN. The last of
// these words is the bias.
//
// Optional build macro:
//   LAYER_SEQ_RELU_EN  -- when defined, negative saturated results become 0.
//
// Ports:
//   clk        in   1     clock, rising edge
//   reset      in   1     synchronous, active-high reset
//   in_valid   in   1     activation beat valid
//   in_ready   out  1     activations accepted (IDLE/LOAD only)
//   in_data    in   DW    activation value (signed, FRAC fractional bits)
//   w_addr     out  AW    weight ROM address
//   w_data     in   DW    weight ROM data, one cycle after w_addr
//   out_valid  out  1     result valid (held until out_ready)
//   out_ready  in   1     result consumer ready
//   out_data   out  DW    saturated neuron result
//   out_idx    out  4     neuron index of out_data
//   busy       out  1     computing (not IDLE/LOAD)
//   done       out  1     one-cycle pulse after the last result handshake
// ---------------------------------------------------------------------------
module layer_seq #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 8,
  parameter int DW    = 16,
  parameter int FRAC  = 8,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic [AW-1:0]        w_addr,
  input  logic signed [DW-1:0] w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [3:0]           out_idx,
  output logic                 busy,
  output logic                 done
);

  // The accumulator carries 4 guard bits, so up to 16 full-scale products
  // can be summed without wrapping.
  localparam int          ACCW   = 2 * DW + 4;
  localparam int          KW     = $clog2(N_IN + 1);
  localparam int          NW     = $clog2(N_IN);
  localparam logic [31:0] STRIDE = 32'(N_IN + 1);

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADDR,
    DRAIN,
    OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic signed [DW-1:0]    r_act [N_IN];
  logic [NW-1:0]           r_n;
  logic [KW-1:0]           r_k;
  logic [3:0]              r_j;
  logic signed [ACCW-1:0]  r_acc;
  logic signed [DW-1:0]    r_out_data;
  logic [3:0]              r_out_idx;
  logic                    r_done;

  logic                    w_beat;
  logic                    w_last_k;
  logic                    w_last_j;
  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACCW-1:0]  w_bias_ext;
  logic signed [ACCW-1:0]  w_sum;
  logic signed [ACCW-1:0]  w_shr;
  logic signed [DW-1:0]    w_sat;
  logic signed [DW-1:0]    w_res;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking (<=) assignments so that all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_last_k = (r_k == KW'(N_IN));
  assign w_last_j = (r_j == 4'(N_OUT - 1));

  // -------------------------------------------------------------------------
  // FSM next-state and state-decoded outputs
  // -------------------------------------------------------------------------
  // NOTE: each output of this block gets a default before the case statement.
  // That way no path leaves a signal unassigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_n == NW'(N_IN - 1))) w_state_nxt = ADDR;
      end
      ADDR: begin
        busy = 1'b1;
        if (w_last_k) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = w_last_j ? IDLE : ADDR;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_beat = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Activation storage
  // -------------------------------------------------------------------------
  // NOTE: the activation array has no reset. It is always fully rewritten by
  // a load before any neuron reads it, and leaving it unreset keeps it
  // mappable to plain RAM/flops without reset wiring.
  always_ff @(posedge clk) begin
    if (w_beat) r_act[r_n] <= in_data;
  end

  // -------------------------------------------------------------------------
  // Datapath: shared multiplier, accumulator, bias/rescale/saturate
  // -------------------------------------------------------------------------
  // The address issued while k>0 returns data one cycle later. That data is
  // the weight for act[k-1], so the multiplier always pairs with the previous
  // index. At k=0 the product is discarded.
  assign w_prod     = r_act[NW'(r_k - KW'(1))] * w_data;
  assign w_bias_ext = ACCW'(w_data) <<< FRAC;
  assign w_sum      = r_acc + w_bias_ext;
  assign w_shr      = w_sum >>> FRAC;

  always_comb begin
    if (w_shr > SAT_MAX)      w_sat = {1'b0, {(DW - 1){1'b1}}};
    else if (w_shr < SAT_MIN) w_sat = {1'b1, {(DW - 1){1'b0}}};
    else                      w_sat = w_shr[DW-1:0];
  end

`ifdef LAYER_SEQ_RELU_EN
  assign w_res = w_sat[DW-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n        <= '0;
      r_k        <= '0;
      r_j        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_beat) r_n <= r_n + NW'(1);
        end
        LOAD: begin
          if (w_beat) begin
            if (r_n == NW'(N_IN - 1)) begin
              r_n   <= '0;
              r_j   <= '0;
              r_k   <= '0;
              r_acc <= '0;
            end else begin
              r_n <= r_n + NW'(1);
            end
          end
        end
        ADDR: begin
          if (r_k != '0) r_acc <= r_acc + ACCW'(w_prod);
          // k parks on the bias address, so w_addr stays put through DRAIN/OUT.
          if (!w_last_k) r_k <= r_k + KW'(1);
        end
        DRAIN: begin
          r_out_data <= w_res;
          r_out_idx  <= r_j;
        end
        OUT: begin
          if (out_ready) begin
            r_k   <= '0;
            r_acc <= '0;
            if (w_last_j) begin
              r_j    <= '0;
              r_done <= 1'b1;
            end else begin
              r_j <= r_j + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_addr   = AW'(32'(r_j) * STRIDE + 32'(r_k));
  assign out_data = r_out_data;
  assign out_idx  = r_out_idx;
  assign done     = r_done;

endmodule

// File: tb/tb_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_layer_seq -- self-checking bench for layer_seq (N_IN=10, N_OUT=2,
// FRAC=8). It uses a behavioural ROM and a dot-product reference model.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_layer_seq;

  localparam int N_IN  = 10;
  localparam int N_OUT = 2;
  localparam int DW    = 16;
  localparam int FRAC  = 8;
  localparam int AW    = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [AW-1:0]        w_addr;
  logic signed [DW-1:0] w_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_idx;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [DW-1:0] rom [0:(1<<AW)-1];
  int                   acts [N_IN];

  layer_seq #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .DW   (DW),
    .FRAC (FRAC),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Weight ROM with one cycle of read latency.
  always @(posedge clk) w_data <= rom[w_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference: full-precision dot product + bias, floor-divide by 2^FRAC,
  // clamp to the DW-bit signed range, optional ReLU.
  function automatic longint model(input int j);
    longint sum;
    longint r;
    sum = 0;
    for (int i = 0; i < N_IN; i++)
      sum += longint'(acts[i]) * longint'(rom[j*(N_IN+1) + i]);
    sum += longint'(rom[j*(N_IN+1) + N_IN]) * (longint'(1) << FRAC);
    r = sum >>> FRAC;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`ifdef LAYER_SEQ_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic set_layer(input int a, input int w0, input int b0, input int w1, input int b1);
    for (int i = 0; i < N_IN; i++) begin
      acts[i]                = a;
      rom[i]                 = DW'(w0);
      rom[(N_IN+1) + i]      = DW'(w1);
    end
    rom[N_IN]             = DW'(b0);
    rom[(N_IN+1) + N_IN]  = DW'(b1);
  endtask

  task automatic set_random(input int arange, input int wrange);
    for (int i = 0; i < N_IN; i++)
      acts[i] = int'($urandom_range(0, 2*arange)) - arange;
    for (int a = 0; a < N_OUT*(N_IN+1); a++)
      rom[a] = DW'(int'($urandom_range(0, 2*wrange)) - wrange);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_in_ready"},  longint'(in_ready),  1);
    check({name, "_out_valid"}, longint'(out_valid), 0);
    check({name, "_busy"},      longint'(busy),      0);
    check({name, "_done"},      longint'(done),      0);
    check({name, "_out_data"},  longint'(out_data),  0);
    check({name, "_out_idx"},   longint'(out_idx),   0);
    check({name, "_w_addr"},    longint'(w_addr),    0);
  endtask

  // Loads the activations, then collects N_OUT results. With abort_j >= 0,
  // reset is asserted while neuron abort_j is at ADDR step abort_k.
  task automatic run_layer(input string name, input bit stall, input int abort_j, input int abort_k);
    int     cyc;
    longint exp;
    for (int i = 0; i < N_IN; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(acts[i]);
      if (i == 0 || i == N_IN-1) check($sformatf("%s_in_ready_load%0d", name, i), longint'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check({name, "_busy_start"},     longint'(busy),     1);
    check({name, "_in_ready_busy"},  longint'(in_ready), 0);

    for (int j = 0; j < N_OUT; j++) begin
      exp = model(j);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
        if (j == abort_j && cyc == abort_k) begin
          reset    = 1'b1;
          in_valid = 1'b0;
          @(posedge clk); #1;
          check_reset_state({name, "_abort"});
          reset = 1'b0;
          return;
        end
        // Junk on the load port while busy must not disturb act[].
        in_valid = 1'($urandom);
        in_data  = DW'($urandom);
        @(posedge clk); #1;
        cyc++;
      end
      in_valid = 1'b0;
      check($sformatf("%s_valid%0d", name, j),   longint'(out_valid), 1);
      check($sformatf("%s_latency%0d", name, j), longint'(cyc), N_IN + 2);
      check($sformatf("%s_idx%0d", name, j),     longint'(out_idx), j);
      check($sformatf("%s_data%0d", name, j),    longint'(out_data), exp);
      if (stall) begin
        for (int s = 0; s < 5; s++) begin
          out_ready = 1'b0;
          in_valid  = 1'($urandom);
          in_data   = DW'($urandom);
          @(posedge clk); #1;
          check($sformatf("%s_stall_valid%0d", name, j), longint'(out_valid), 1);
          check($sformatf("%s_stall_data%0d", name, j),  longint'(out_data), exp);
          check($sformatf("%s_stall_idx%0d", name, j),   longint'(out_idx), j);
          check($sformatf("%s_stall_addr%0d", name, j),  longint'(w_addr), j*(N_IN+1) + N_IN);
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (j == N_OUT-1) begin
        check({name, "_done_pulse"}, longint'(done),      1);
        check({name, "_idle_busy"},  longint'(busy),      0);
        check({name, "_idle_ready"}, longint'(in_ready),  1);
        check({name, "_idle_valid"}, longint'(out_valid), 0);
        @(posedge clk); #1;
        check({name, "_done_clear"}, longint'(done),      0);
      end else begin
        check($sformatf("%s_done_early%0d", name, j), longint'(done), 0);
        check($sformatf("%s_busy_next%0d", name, j),  longint'(busy), 1);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int a = 0; a < (1<<AW); a++) rom[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    set_layer(256, 256, 0, 256, 0);
    run_layer("unit", 1'b0, -1, 0);

    set_layer(256, -256, 0, -256, 0);
    run_layer("neg", 1'b0, -1, 0);

    set_layer(32767, 32767, 0, -32768, 0);
    run_layer("sat", 1'b0, -1, 0);

    set_layer(0, 100, 5, 100, -3);
    run_layer("bias", 1'b0, -1, 0);

    set_random(1024, 512);
    run_layer("stall", 1'b1, -1, 0);

    set_random(1024, 512);
    run_layer("abort", 1'b0, 1, 4);
    set_layer(256, 256, 0, 256, 0);
    run_layer("reload", 1'b0, -1, 0);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) set_random(2000, 1000);
      else            set_random(32768, 32768);
      run_layer($sformatf("rand%0d", t), 1'($urandom), -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 SHALL have parameter N_IN, default 10: activations per neuron.
REQ-002 SHALL have parameter N_OUT, default 8: neurons sequenced per layer.
REQ-003 SHALL have parameter DW, default 16: signed activation/weight/output width.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of the fixed-point format.
REQ-005 SHALL have parameter AW, default 8: weight-memory address width.
REQ-006 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports in_valid in 1 / in_ready out 1 / in_data in DW: activation load stream.
REQ-009 SHALL have ports w_addr out AW / w_data in DW: external weight ROM with 1-cycle read latency.
REQ-010 SHALL have ports out_valid out 1 / out_ready in 1 / out_data out DW / out_idx out 4: result stream.
REQ-011 SHALL have ports busy out 1 (state not IDLE/LOAD) and done out 1 (single-cycle pulse).

Function
REQ-012 SHALL use states IDLE, LOAD, ADDR, DRAIN, OUT and one shared signed DW x DW multiplier with one accumulator.
REQ-013 SHALL assert in_ready only in IDLE/LOAD; each beat (in_valid & in_ready) writes act[n], n = 0..N_IN-1.
REQ-014 SHALL go IDLE->LOAD on the first beat, and LOAD->ADDR on beat N_IN-1 with j=0, k=0, acc=0.
REQ-015 SHALL, in ADDR, drive w_addr = j*(N_IN+1)+k and increment k; when k>0, add act[k-1]*w_data to acc.
REQ-016 SHALL go ADDR->DRAIN after the cycle with k=N_IN; that cycle's address is the bias word.
REQ-017 SHALL, in DRAIN, form r = (acc + (w_data <<< FRAC)) >>> FRAC, an arithmetic floor shift.
REQ-018 SHALL, in DRAIN, saturate r to [-2^(DW-1), 2^(DW-1)-1] and register it into out_data with out_idx=j, then go to OUT.
REQ-019 SHALL size the accumulator to 2*DW+4 bits so it cannot wrap for N_IN<=16.
REQ-020 SHALL hold out_valid=1 in OUT, with out_data/out_idx/w_addr stable until out_ready.
REQ-021 SHALL, on OUT with out_ready and j<N_OUT-1, move to ADDR with j+1, k=0, acc=0.
REQ-022 SHALL, on OUT with out_ready and j=N_OUT-1, move to IDLE and pulse done for one cycle.
REQ-023 SHALL assert the first out_valid exactly N_IN+2 cycles after entering ADDR (12 for N_IN=10).
REQ-024 SHALL ignore in_valid while busy; act[] SHALL NOT change during computation.

Reset
REQ-025 SHALL, on reset (including mid-operation), go to IDLE next cycle.
REQ-026 SHALL, on reset, drive out_valid=0, out_data=0, out_idx=0, w_addr=0, busy=0, done=0 and clear j, k, n, acc.
REQ-027 SHALL leave act[] contents undefined after reset; they are rewritten before use.

Configuration
REQ-028 SHALL, with LAYER_SEQ_RELU_EN defined, replace negative saturated results with 0 (ReLU).
REQ-029 SHALL, without LAYER_SEQ_RELU_EN, pass the signed saturated result unchanged.

Verification (N_IN=10, N_OUT=2, FRAC=8)
REQ-030 SHALL cover: all acts 256, weights 256, bias 0 -> out_data 2560 with idx 0 then 1; first out_valid 12 cycles after ADDR entry; done after 2nd handshake.
REQ-031 SHALL cover: acts 256, weights -256 -> 0 with LAYER_SEQ_RELU_EN; -2560 (0xF600) without.
REQ-032 SHALL cover: acts 32767, weights 32767 -> 32767; weights -32768 -> -32768 without ReLU.
REQ-033 SHALL cover: acts 0, bias 5 -> out_data 5; bias -3 -> 0 with ReLU.
REQ-034 SHALL cover: out_ready low 5 cycles in OUT -> out_valid/out_data/out_idx/w_addr stable, no idx-1 result until the handshake.
REQ-035 SHALL cover: reset during ADDR (j=1, k=4) -> next cycle IDLE, in_ready=1, out_valid=0, busy=0; a fresh load then reproduces REQ-030.
